// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache between the core fetch port and an SRAM-like memory channel.
// Hits answer combinationally; misses refill a line word by word; kseg1 fetches go out as single uncached reads.
module icache_direct #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        stall,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);
  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int CNT_WIDTH = OFFSET_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << CNT_WIDTH;

  typedef enum logic [2:0] {IDLE, MREQ, MWAIT, UREQ, UWAIT, UDONE} state_t;
  state_t state, state_next;

  logic [LINES-1:0]     valid;
  logic [TAG_WIDTH-1:0] tag_array  [LINES];
  logic [31:0]          data_array [LINES][WORDS];
  logic [31:0]          miss_addr;
  logic [31:0]          unc_data;
  logic [CNT_WIDTH-1:0] cnt;

  logic [31:0]            phys;
  logic                   cached;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [CNT_WIDTH-1:0]   req_word;
  logic [INDEX_WIDTH-1:0] fill_index;
  logic [TAG_WIDTH-1:0]   fill_tag;
  logic                   hit;
  logic                   latch_miss, latch_unc, fill_we, unc_we;
  logic                   unused_ok;

  assign phys       = {3'b000, inst_sram_addr[28:0]};
  assign cached     = (inst_sram_addr[31:29] != 3'b101);
  assign req_tag    = phys[31 -: TAG_WIDTH];
  assign req_index  = phys[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word   = phys[2 +: CNT_WIDTH];
  assign fill_index = miss_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign fill_tag   = miss_addr[31 -: TAG_WIDTH];
  assign hit        = inst_sram_en & cached & valid[req_index] & (tag_array[req_index] == req_tag);
  assign unused_ok  = ^phys[1:0];

  // Memory channel: inst_req is a pure function of state, so an async reset drops it immediately.
  // A request is held with a fixed address until inst_addr_ok is sampled high; then exactly one
  // inst_data_ok is awaited before the next request may be raised.
  assign inst_req   = (state == MREQ) || (state == UREQ);
  assign inst_addr  = miss_addr | {{(32-OFFSET_WIDTH){1'b0}}, cnt, 2'b00};
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'h0;

  assign stall           = inst_sram_en & ~(((state == IDLE) & hit) | (state == UDONE));
  assign inst_sram_rdata = (state == UDONE) ? unc_data : data_array[req_index][req_word];

  always_comb begin
    state_next = state;
    latch_miss = 1'b0;
    latch_unc  = 1'b0;
    fill_we    = 1'b0;
    unc_we     = 1'b0;
    case (state)
      IDLE: begin
        if (inst_sram_en) begin
          if (!cached) begin
            latch_unc  = 1'b1;
            state_next = UREQ;
          end else if (!hit) begin
            latch_miss = 1'b1;
            state_next = MREQ;
          end
        end
      end
      MREQ:  if (inst_addr_ok) state_next = MWAIT;
      MWAIT: begin
        if (inst_data_ok) begin
          fill_we    = 1'b1;
          state_next = (&cnt) ? IDLE : MREQ;
        end
      end
      UREQ:  if (inst_addr_ok) state_next = UWAIT;
      UWAIT: begin
        if (inst_data_ok) begin
          unc_we     = 1'b1;
          state_next = UDONE;
        end
      end
      UDONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= 32'h0;
      unc_data  <= 32'h0;
      cnt       <= '0;
    end else begin
      state <= state_next;
      if (latch_miss) begin
        miss_addr <= {phys[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        cnt       <= '0;
      end
      // Uncached reads reuse the same address register with cnt held at zero.
      if (latch_unc) begin
        miss_addr <= phys;
        cnt       <= '0;
      end
      // The line becomes valid only with its final word, so a partial line never hits.
      if (fill_we) begin
        if (&cnt) valid[fill_index] <= 1'b1;
        else      cnt <= cnt + 1'b1;
      end
      if (unc_we) unc_data <= inst_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_array[fill_index][cnt] <= inst_rdata;
      if (&cnt) tag_array[fill_index] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: a fetch driver, a randomised SRAM-like memory responder, a
// direct-mapped reference model, and a monitor that pops expected fetch data from a queue.
module tb_icache_direct;
  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [31:0] addr;
  logic [31:0] sram_rdata;
  logic        stall;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        mem_addr_ok, mem_data_ok, spur;
  logic [31:0] mem_rdata;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  int errors = 0;
  int checks = 0;
  int req_cnt = 0;
  int data_cnt = 0;
  bit slow = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] req_q[$];
  bit          mdl_valid [64];
  logic [21:0] mdl_tag   [64];

  assign inst_data_ok = mem_data_ok | spur;
  assign inst_rdata   = spur ? 32'hDEADBEEF : mem_rdata;

  always #5 clk = ~clk;

  icache_direct dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(en), .inst_sram_addr(addr), .inst_sram_rdata(sram_rdata), .stall(stall),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(mem_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pa);
    if (pa == 32'h1FC00000) return 32'h3C080001;
    if (pa[31:4] == 28'h0) return (32'(pa[3:2]) + 32'd1) * 32'h11;
    return (pa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Reference model: a 64-line, 4-word direct-mapped tag store over physical addresses.
  task automatic model_access(input logic [31:0] a, output logic [31:0] d);
    logic [31:0] pa;
    int idx;
    pa  = {3'b000, a[28:0]};
    idx = int'(pa[9:4]);
    d   = mem_word(pa);
    if (a[31:29] == 3'b101) begin
      req_q.push_back(pa);
    end else if (!(mdl_valid[idx] && mdl_tag[idx] == pa[31:10])) begin
      for (int w = 0; w < 4; w++) req_q.push_back({pa[31:4], 4'h0} + 32'(w * 4));
      mdl_valid[idx] = 1'b1;
      mdl_tag[idx]   = pa[31:10];
    end
  endtask

  task automatic fetch(input logic [31:0] a, output int stalls);
    logic [31:0] d;
    bit done;
    model_access(a, d);
    exp_q.push_back(d);
    en = 1'b1;
    addr = a;
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
      else stalls++;
    end
    check("fetch_done", 32'(done), 32'd1);
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  // Memory responder: decisions made at negedge, seen by the DUT at the next posedge.
  initial begin : mem_proc
    bit phase, req_seen;
    int waited, target;
    logic [31:0] seen, cur;
    phase = 1'b0; req_seen = 1'b0; waited = 0; target = 0; seen = 0; cur = 0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (!resetn) begin
        phase = 1'b0;
        req_seen = 1'b0;
      end else if (!phase) begin
        if (inst_req) begin
          if (!req_seen) begin
            req_seen = 1'b1;
            seen = inst_addr;
            waited = 0;
            target = slow ? 3 : int'($urandom_range(0, 2));
          end else begin
            check("addr_stable", inst_addr, seen);
          end
          if (waited >= target) begin
            if (req_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL req_unexpected: got %h expected no request", inst_addr);
            end else begin
              check("req_addr", inst_addr, req_q.pop_front());
            end
            cur = inst_addr;
            mem_addr_ok = 1'b1;
            req_cnt++;
            phase = 1'b1;
            req_seen = 1'b0;
            waited = 0;
            target = slow ? 5 : int'($urandom_range(0, 3));
          end else begin
            waited++;
          end
        end else if (req_seen) begin
          check("req_held", 32'(inst_req), 32'd1);
          req_seen = 1'b0;
        end
      end else begin
        if (waited >= target) begin
          mem_data_ok = 1'b1;
          mem_rdata = mem_word(cur);
          data_cnt++;
          phase = 1'b0;
        end else begin
          waited++;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (resetn && en && !stall) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata_unexpected: got %h expected no completion", sram_rdata);
        end else begin
          check("rdata", sram_rdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int s, r0, base;
    bit reached;
    logic [31:0] d, a;
    resetn = 1'b0; en = 1'b0; addr = 32'h0; spur = 1'b0;
    for (int i = 0; i < 64; i++) begin mdl_valid[i] = 1'b0; mdl_tag[i] = '0; end

    #3;
    check("rst_req", 32'(inst_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("const_wr", 32'(inst_wr), 32'd0);
    check("const_size", 32'(inst_size), 32'd2);
    check("const_wdata", inst_wdata, 32'd0);
    en = 1'b1; addr = 32'h80000000;
    #1 check("rst_stall_en", 32'(stall), 32'd1);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // kseg1 bypass, twice: each one is a single uncached request.
    r0 = req_cnt; fetch(32'hBFC00000, s); check("unc_reqs1", 32'(req_cnt - r0), 32'd1);
    r0 = req_cnt; fetch(32'hBFC00000, s); check("unc_reqs2", 32'(req_cnt - r0), 32'd1);

    // Cached line fill then hit on another word.
    r0 = req_cnt; fetch(32'h80000008, s); check("fill_reqs", 32'(req_cnt - r0), 32'd4);
    r0 = req_cnt; fetch(32'h8000000C, s);
    check("hit_reqs", 32'(req_cnt - r0), 32'd0);
    check("hit_stalls", 32'(s), 32'd0);

    // Conflict on index 0.
    r0 = req_cnt; fetch(32'h80000000, s); check("conf_hit", 32'(req_cnt - r0), 32'd0);
    r0 = req_cnt; fetch(32'h80000400, s); check("conf_fill", 32'(req_cnt - r0), 32'd4);
    r0 = req_cnt; fetch(32'h80000000, s); check("conf_refill", 32'(req_cnt - r0), 32'd4);

    // Slow handshake: per word 4 MREQ + 6 MWAIT cycles, plus the detecting IDLE cycle.
    slow = 1'b1;
    r0 = req_cnt; fetch(32'h80001238, s);
    check("slow_reqs", 32'(req_cnt - r0), 32'd4);
    check("slow_stalls", 32'(s), 32'd41);
    slow = 1'b0;

    // Reset in the middle of a refill, after two words.
    a = 32'h80002040;
    model_access(a, d);
    base = data_cnt;
    en = 1'b1; addr = a;
    reached = 1'b0;
    for (int i = 0; i < 300 && !reached; i++) begin
      @(negedge clk);
      if (data_cnt >= base + 2) reached = 1'b1;
    end
    check("mid_reached", 32'(reached), 32'd1);
    @(posedge clk);
    #2;
    check("mid_req", 32'(inst_req), 32'd1);
    check("mid_addr", inst_addr, 32'h00002048);
    resetn = 1'b0;
    #1;
    check("mid_req_drop", 32'(inst_req), 32'd0);
    en = 1'b0;
    req_q.delete();
    for (int i = 0; i < 64; i++) mdl_valid[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    r0 = req_cnt; fetch(a, s); check("post_rst_reqs", 32'(req_cnt - r0), 32'd4);

    // Spurious data_ok while idle with en low.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 spur = (i % 2 == 0);
      @(negedge clk);
      check("spur_stall", 32'(stall), 32'd0);
      check("spur_req", 32'(inst_req), 32'd0);
    end
    @(posedge clk);
    #1 spur = 1'b0;
    r0 = req_cnt; fetch(a, s);
    check("spur_hit_reqs", 32'(req_cnt - r0), 32'd0);
    check("spur_hit_stalls", 32'(s), 32'd0);

    // Random fetches over a small aliasing address space.
    for (int n = 0; n < 80; n++) begin
      int sel;
      logic [2:0] top;
      sel = int'($urandom_range(0, 9));
      top = (sel < 2) ? 3'b101 : (sel < 5) ? 3'b000 : 3'b100;
      a = {top, 29'h0} | (32'($urandom_range(0, 3)) << 10)
                       | (32'($urandom_range(0, 7)) << 4)
                       | (32'($urandom_range(0, 3)) << 2);
      fetch(a, s);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("req_q_empty", 32'(req_q.size()), 32'd0);
    check("end_wr", 32'(inst_wr), 32'd0);
    check("end_size", 32'(inst_size), 32'd2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
